// File: rtl/cdc_pkg.sv
// Shared definitions for the source-domain pulse throttle and the toggle
// synchronizer that follows it: FSM encodings and default sizing constants.
package cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } thr_state_e;

  localparam int unsigned CDC_MIN_GAP = 6;
  localparam int unsigned CDC_CNT_W   = 4;

endpackage

// File: rtl/pulse_gap_timer.sv
// Load/decrement down-counter that times the quiet interval after each
// emitted pulse; o_done is high while the count is zero.
module pulse_gap_timer #(
  parameter int unsigned MIN_GAP = 6
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_done
);

  localparam int unsigned W = $clog2(MIN_GAP);
  localparam logic [W-1:0] LOAD_VAL = W'(MIN_GAP - 2);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/pulse_throttle.sv
// Counts incoming event pulses and re-emits them one at a time, spaced
// MIN_GAP cycles apart. Define PULSE_THROTTLE_OVF_EN for the sticky ovf flag.
module pulse_throttle
  import cdc_pkg::*;
#(
  parameter int unsigned CNT_W   = CDC_CNT_W,
  parameter int unsigned MIN_GAP = CDC_MIN_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_pulse,
  output logic             out_pulse,
  output logic [CNT_W-1:0] pending,
  output logic             busy
`ifdef PULSE_THROTTLE_OVF_EN
  ,
  output logic             ovf,
  input  logic             ovf_clr
`endif
);

  thr_state_e       r_state;
  thr_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_pending;
  logic             r_out_pulse;
  logic             w_gap_done;
  logic             w_pend_nz;
  logic             w_enter_emit;
  logic             w_full;

  assign w_pend_nz    = (r_pending != '0);
  assign w_enter_emit = (w_state_nxt == ST_EMIT);
  assign w_full       = (r_pending == {CNT_W{1'b1}});

  pulse_gap_timer #(
    .MIN_GAP (MIN_GAP)
  ) u_gap_timer (
    .clk     (clk),
    .i_rst_n (reset),
    .i_load  (r_state == ST_EMIT),
    .i_dec   (r_state == ST_GAP),
    .o_done  (w_gap_done)
  );

  // NOTE: next state defaults to the current state before the case so no
  // path through the block leaves it unassigned (no latch is inferred).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pend_nz) w_state_nxt = ST_EMIT;
      ST_EMIT: w_state_nxt = ST_GAP;
      ST_GAP:  if (w_gap_done) w_state_nxt = w_pend_nz ? ST_EMIT : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // out_pulse is registered from the next state so it is a clean flop output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_out_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_pulse <= w_enter_emit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending <= '0;
    end else if (in_pulse && !w_enter_emit && !w_full) begin
      r_pending <= r_pending + CNT_W'(1);
    end else if (w_enter_emit && !in_pulse) begin
      r_pending <= r_pending - CNT_W'(1);
    end
  end

`ifdef PULSE_THROTTLE_OVF_EN
  logic w_drop;
  logic r_ovf;

  assign w_drop = in_pulse && !w_enter_emit && w_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

  assign out_pulse = r_out_pulse;
  assign pending   = r_pending;
  assign busy      = (r_state != ST_IDLE) || w_pend_nz;

endmodule

// File: tb/tb_pulse_throttle.sv
// Directed bench for pulse_throttle: table-driven cycle vectors on a default
// instance, plus saturation (CNT_W=2) and a toggle-synchronizer end-to-end run.
module tb_pulse_throttle;
  import cdc_pkg::*;

  logic clk  = 1'b0;
  logic clk2 = 1'b0;
  always #5  clk  = ~clk;
  always #10 clk2 = ~clk2;

  logic       a_reset = 1'b0;
  logic       a_in    = 1'b0;
  logic       a_out;
  logic [3:0] a_pending;
  logic       a_busy;
  logic       b_reset = 1'b0;
  logic       b_in    = 1'b0;
  logic       b_out;
  logic [1:0] b_pending;
  logic       b_busy;
`ifdef PULSE_THROTTLE_OVF_EN
  logic a_ovf;
  logic a_ovf_clr = 1'b0;
  logic b_ovf;
  logic b_ovf_clr = 1'b0;
`endif

  pulse_throttle #(.CNT_W(4), .MIN_GAP(6)) u_dut_a (
    .clk       (clk),
    .reset     (a_reset),
    .in_pulse  (a_in),
    .out_pulse (a_out),
    .pending   (a_pending),
    .busy      (a_busy)
`ifdef PULSE_THROTTLE_OVF_EN
    ,
    .ovf       (a_ovf),
    .ovf_clr   (a_ovf_clr)
`endif
  );

  pulse_throttle #(.CNT_W(2), .MIN_GAP(6)) u_dut_b (
    .clk       (clk),
    .reset     (b_reset),
    .in_pulse  (b_in),
    .out_pulse (b_out),
    .pending   (b_pending),
    .busy      (b_busy)
`ifdef PULSE_THROTTLE_OVF_EN
    ,
    .ovf       (b_ovf),
    .ovf_clr   (b_ovf_clr)
`endif
  );

  // Toggle synchronizer model into a 2x slower destination clock.
  logic tog = 1'b0;
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  int   sync_cnt = 0;
  int   b_pulses = 0;

  always @(posedge clk) begin
    if (a_out === 1'b1) tog <= ~tog;
    if (b_out === 1'b1) b_pulses <= b_pulses + 1;
  end

  always @(posedge clk2) begin
    s1 <= tog;
    s2 <= s1;
    s3 <= s2;
    if (s2 ^ s3) sync_cnt <= sync_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic       in;
    logic       out;
    logic [3:0] pend;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic i, input logic o,
                     input logic [3:0] p, input logic b);
    vec_t v;
    v.rst_n = r; v.in = i; v.out = o; v.pend = p; v.busy = b;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  int sat_exp[6] = '{1, 1, 2, 3, 3, 3};
  int base;

  initial begin
    // Each row: inputs held across one rising edge, outputs expected after it.
    add(3, 0, 1, 0, 0, 0);                       // reset wins over in_pulse
    add(1, 1, 0, 0, 0, 0);
    // single event
    add(1, 1, 1, 0, 1, 1);
    add(1, 1, 0, 1, 0, 1);
    add(5, 1, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0);
    // three-cycle burst: pulses 6 cycles apart
    add(1, 1, 1, 0, 1, 1);
    add(1, 1, 1, 1, 1, 1);
    add(1, 1, 1, 0, 2, 1);
    add(4, 1, 0, 0, 2, 1);
    add(1, 1, 0, 1, 1, 1);
    add(5, 1, 0, 0, 1, 1);
    add(1, 1, 0, 1, 0, 1);
    add(5, 1, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0);
    // event landing on the GAP->EMIT edge leaves pending unchanged
    add(1, 1, 1, 0, 1, 1);
    add(1, 1, 0, 1, 0, 1);
    add(3, 1, 0, 0, 0, 1);
    add(1, 1, 1, 0, 1, 1);
    add(1, 1, 0, 0, 1, 1);
    add(1, 1, 1, 1, 1, 1);
    add(5, 1, 0, 0, 1, 1);
    add(1, 1, 0, 1, 0, 1);
    add(5, 1, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0);
    // reset during GAP discards pending events
    add(1, 1, 1, 0, 1, 1);
    add(1, 1, 1, 1, 1, 1);
    add(1, 1, 1, 0, 2, 1);
    add(1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    // reset during EMIT
    add(1, 1, 1, 0, 1, 1);
    add(1, 1, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0);
    add(7, 1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      a_reset = vecs[i].rst_n;
      a_in    = vecs[i].in;
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_pulse", i), 32'(a_out), 32'(vecs[i].out));
      check($sformatf("v%0d pending", i), 32'(a_pending), 32'(vecs[i].pend));
      check($sformatf("v%0d busy", i), 32'(a_busy), 32'(vecs[i].busy));
`ifdef PULSE_THROTTLE_OVF_EN
      check($sformatf("v%0d ovf", i), 32'(a_ovf), 32'd0);
`endif
    end

    // Saturation on CNT_W=2: six back-to-back events, two dropped.
    b_reset = 1'b0;
    repeat (2) @(posedge clk);
    b_reset = 1'b1;
    @(posedge clk);
    #1;
    base = b_pulses;
    for (int k = 0; k < 6; k++) begin
      b_in = 1'b1;
`ifdef PULSE_THROTTLE_OVF_EN
      b_ovf_clr = 1'b1;                          // set must win over clear
`endif
      @(posedge clk);
      #1;
      check($sformatf("sat%0d pending", k), 32'(b_pending), 32'(sat_exp[k]));
`ifdef PULSE_THROTTLE_OVF_EN
      check($sformatf("sat%0d ovf", k), 32'(b_ovf), (k >= 4) ? 32'd1 : 32'd0);
`endif
    end
    b_in = 1'b0;
`ifdef PULSE_THROTTLE_OVF_EN
    b_ovf_clr = 1'b0;
`endif
    repeat (40) @(posedge clk);
    #1;
    check("sat pulse count", 32'(b_pulses - base), 32'd4);
    check("sat drained pending", 32'(b_pending), 32'd0);
    check("sat drained busy", 32'(b_busy), 32'd0);
`ifdef PULSE_THROTTLE_OVF_EN
    check("sat ovf sticky", 32'(b_ovf), 32'd1);
    b_ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    b_ovf_clr = 1'b0;
    check("sat ovf cleared", 32'(b_ovf), 32'd0);
`endif

    // End-to-end through the toggle synchronizer: 5 back-to-back events.
    base = sync_cnt;
    a_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    a_in = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("e2e sync pulses", 32'(sync_cnt - base), 32'd5);
    check("e2e pending", 32'(a_pending), 32'd0);
    check("e2e busy", 32'(a_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
